// File: rtl/hgcal_input_packer_pkg.sv
// Shared types and sizing helpers for the HGCAL input packer and related input stages.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package hgcal_input_packer_pkg;

    // Packer control states: filling a frame, holding a finished frame, discarding an overlong frame
    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } pack_state_t;

    // Default configuration of the autoencoder first layer
    localparam int NUM_INPUTS_DEF = 48;
    localparam int QBITS_DEF      = 2;
    localparam int VEC_W          = NUM_INPUTS_DEF * QBITS_DEF;
    localparam int IDX_W          = $clog2(NUM_INPUTS_DEF);
    localparam int CODE_MAX       = (1 << QBITS_DEF) - 1;

    // Sizing helpers so parameterised instances derive the same quantities
    function automatic int vec_width(input int num_inputs, input int qbits);
        return num_inputs * qbits;
    endfunction

    function automatic int idx_width(input int num_inputs);
        return (num_inputs < 2) ? 1 : $clog2(num_inputs);
    endfunction

    function automatic int code_max(input int qbits);
        return (1 << qbits) - 1;
    endfunction

endpackage

// File: rtl/hgcal_sample_quant.sv
// Quantizes one unsigned sample: right shift, then saturate to the largest QBITS code.
// Latency: purely combinational, no rounding.
// Backpressure: none; output follows input.
module hgcal_sample_quant
    import hgcal_input_packer_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int QBITS    = 2,
    parameter int SHIFT    = 4
) (
    input  logic [SAMPLE_W-1:0] sample,
    output logic [QBITS-1:0]    code
);

    localparam logic [SAMPLE_W-1:0] CMAX_WIDE = SAMPLE_W'(code_max(QBITS));
    localparam logic [QBITS-1:0]    CMAX      = QBITS'(code_max(QBITS));

    logic [SAMPLE_W-1:0] q;

    // Shift away the low bits, then clamp anything above the code range
    always_comb begin
        q    = sample >> SHIFT;
        code = (q > CMAX_WIDE) ? CMAX : q[QBITS-1:0];
    end

endmodule

// File: rtl/hgcal_input_packer.sv
// Packs a serial stream of quantized samples into one wide frame vector for LUT layer 1.
// Latency: m_valid rises 1 cycle after the last sample of a well-formed frame is accepted.
// Backpressure: one frame buffered behind the output register; s_ready drops (registered) while it waits.
module hgcal_input_packer
    import hgcal_input_packer_pkg::*;
#(
    parameter int NUM_INPUTS = 48,
    parameter int SAMPLE_W   = 8,
    parameter int QBITS      = 2,
    parameter int SHIFT      = 4,
    parameter int ERR_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SAMPLE_W-1:0]         s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [NUM_INPUTS*QBITS-1:0] m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        frame_err,
    output logic [ERR_W-1:0]            err_count
);

    localparam int              VW       = vec_width(NUM_INPUTS, QBITS);
    localparam int              IW       = idx_width(NUM_INPUTS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_INPUTS - 1);

    pack_state_t     state;
    logic [IW-1:0]   idx;
    logic [VW-1:0]   pack_reg;
    logic [VW-1:0]   merged;
    logic [QBITS-1:0] code;
    logic            accept;
    logic            slot_free;
    logic            at_last;

    hgcal_sample_quant #(
        .SAMPLE_W (SAMPLE_W),
        .QBITS    (QBITS),
        .SHIFT    (SHIFT)
    ) u_quant (
        .sample (s_data),
        .code   (code)
    );

    // Handshake qualifiers and the pack register with the incoming code dropped into its slot
    always_comb begin
        accept    = s_valid && s_ready;
        slot_free = !m_valid || m_ready;
        at_last   = (idx == LAST_IDX);
        merged    = pack_reg;
        merged[idx*QBITS +: QBITS] = code;
    end

    // Frame control, output register and error accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            pack_reg  <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            s_ready   <= 1'b1;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            frame_err <= 1'b0;
            // A consumed vector retires unless a new one loads below in the same cycle
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (accept) begin
                        if (!at_last) begin
                            if (s_last) begin
                                // Short frame: abandon it, slots get rewritten by the next frame
                                frame_err <= 1'b1;
                                if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
                                idx <= '0;
                            end else begin
                                pack_reg <= merged;
                                idx      <= idx + IW'(1);
                            end
                        end else if (s_last) begin
                            idx <= '0;
                            if (slot_free) begin
                                m_data  <= merged;
                                m_valid <= 1'b1;
                            end else begin
                                pack_reg <= merged;
                                state    <= HOLD;
                                s_ready  <= 1'b0;
                            end
                        end else begin
                            // Long frame: flag once, swallow the rest up to s_last
                            frame_err <= 1'b1;
                            if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
                            idx   <= '0;
                            state <= DROP;
                        end
                    end
                end

                HOLD: begin
                    // m_valid is always set here; release the buffered frame on handshake
                    if (m_valid && m_ready) begin
                        m_data  <= pack_reg;
                        m_valid <= 1'b1;
                        state   <= FILL;
                        s_ready <= 1'b1;
                        idx     <= '0;
                    end
                end

                DROP: begin
                    if (accept && s_last) begin
                        state <= FILL;
                        idx   <= '0;
                    end
                end

                default: begin
                    state   <= FILL;
                    s_ready <= 1'b1;
                    idx     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hgcal_input_packer.sv
module tb_hgcal_input_packer;

    localparam int N  = 4;
    localparam int SW = 8;
    localparam int QB = 2;
    localparam int SH = 2;
    localparam int EW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [N*QB-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          frame_err;
    logic [EW-1:0] err_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hgcal_input_packer #(
        .NUM_INPUTS (N),
        .SAMPLE_W   (SW),
        .QBITS      (QB),
        .SHIFT      (SH),
        .ERR_W      (EW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    // Reference quantizer: integer divide by 2^SHIFT, clamp to 3
    function automatic int ref_code(input int s);
        int q;
        q = s / (1 << SH);
        return (q > 3) ? 3 : q;
    endfunction

    // Reference packing: code k weighted by 4^k
    function automatic logic [7:0] ref_vec(input int s0, input int s1, input int s2, input int s3);
        int v;
        v = ref_code(s0) + ref_code(s1) * 4 + ref_code(s2) * 16 + ref_code(s3) * 64;
        return v[7:0];
    endfunction

    task automatic apply_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Offer one sample and wait (bounded) for it to be accepted; returns at #1 after the accepting edge
    task automatic send_sample(input int d, input bit last);
        int n;
        bit acc;
        n = 0; acc = 1'b0;
        s_data = d[SW-1:0]; s_valid = 1'b1; s_last = last;
        while (!acc && n < 50) begin
            acc = s_ready;
            @(posedge clk); #1;
            n++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout: sample %0d not accepted, got s_ready=%b want accept within 50 cycles", d, s_ready);
        end
    endtask

    task automatic test_reset();
        m_ready = 1'b1;
        apply_reset();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (err_count !== 3'd0) begin failures++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        m_ready = 1'b1;
        exp = ref_vec(0, 5, 9, 200);
        send_sample(0, 0); send_sample(5, 0); send_sample(9, 0);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b want 0", m_valid); end
        send_sample(200, 1);
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL basic_latency: got m_valid=%b want 1", m_valid); end
        checks++; if (m_data !== exp) begin failures++; $display("FAIL basic_data: got %h want %h", m_data, exp); end
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle: got m_valid=%b want 0", m_valid); end

        exp = ref_vec(3, 4, 15, 16);
        send_sample(3, 0); send_sample(4, 0); send_sample(15, 0); send_sample(16, 1);
        checks++; if (m_valid !== 1'b1 || m_data !== exp) begin
            failures++; $display("FAIL saturation_data: got v=%b d=%h want v=1 d=%h", m_valid, m_data, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [7:0] ea, eb;
        ea = ref_vec(0, 5, 9, 200);
        eb = ref_vec(255, 255, 255, 255);
        m_ready = 1'b0;
        send_sample(0, 0); send_sample(5, 0); send_sample(9, 0); send_sample(200, 1);
        send_sample(255, 0); send_sample(255, 0); send_sample(255, 0); send_sample(255, 1);
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready_low: got %b want 0", s_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b1 || m_data !== ea) begin
            failures++; $display("FAIL bp_hold_a: got v=%b d=%h want v=1 d=%h", m_valid, m_data, ea);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b1 || m_data !== eb) begin
            failures++; $display("FAIL bp_release_b: got v=%b d=%h want v=1 d=%h", m_valid, m_data, eb);
        end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_s_ready_back: got %b want 1", s_ready); end
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got m_valid=%b want 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] eb;
        eb = ref_vec(100, 40, 8, 255);
        m_ready = 1'b0;
        send_sample(0, 0); send_sample(5, 0); send_sample(9, 0); send_sample(200, 1);
        send_sample(100, 0); send_sample(40, 0); send_sample(8, 0);
        m_ready = 1'b1;
        send_sample(255, 1);
        checks++; if (m_valid !== 1'b1 || m_data !== eb) begin
            failures++; $display("FAIL b2b_replace: got v=%b d=%h want v=1 d=%h", m_valid, m_data, eb);
        end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL b2b_s_ready: got %b want 1", s_ready); end
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got m_valid=%b want 0", m_valid); end
    endtask

    task automatic test_short_frame();
        logic [7:0] exp;
        exp = ref_vec(0, 5, 9, 200);
        m_ready = 1'b1;
        apply_reset();
        send_sample(77, 0); send_sample(130, 1);
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL short_err_pulse: got %b want 1", frame_err); end
        checks++; if (err_count !== 3'd1) begin failures++; $display("FAIL short_err_count: got %0d want 1", err_count); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL short_no_output: got m_valid=%b want 0", m_valid); end
        @(posedge clk); #1;
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL short_pulse_width: got %b want 0", frame_err); end
        send_sample(0, 0); send_sample(5, 0); send_sample(9, 0); send_sample(200, 1);
        checks++; if (m_valid !== 1'b1 || m_data !== exp) begin
            failures++; $display("FAIL short_recover: got v=%b d=%h want v=1 d=%h", m_valid, m_data, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_long_frame();
        logic [7:0] exp;
        bit seen_valid;
        exp = ref_vec(3, 4, 15, 16);
        seen_valid = 1'b0;
        m_ready = 1'b1;
        apply_reset();
        send_sample(10, 0); send_sample(20, 0); send_sample(30, 0);
        send_sample(40, 0);
        checks++; if (frame_err !== 1'b1 || err_count !== 3'd1) begin
            failures++; $display("FAIL long_err_at_4th: got pulse=%b cnt=%0d want pulse=1 cnt=1", frame_err, err_count);
        end
        send_sample(50, 0);
        if (m_valid) seen_valid = 1'b1;
        send_sample(60, 1);
        if (m_valid) seen_valid = 1'b1;
        checks++; if (frame_err !== 1'b0 || err_count !== 3'd1) begin
            failures++; $display("FAIL long_single_err: got pulse=%b cnt=%0d want pulse=0 cnt=1", frame_err, err_count);
        end
        checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL long_no_output: got m_valid seen=%b want 0", seen_valid); end
        send_sample(3, 0); send_sample(4, 0); send_sample(15, 0); send_sample(16, 1);
        checks++; if (m_valid !== 1'b1 || m_data !== exp) begin
            failures++; $display("FAIL long_recover: got v=%b d=%h want v=1 d=%h", m_valid, m_data, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp;
        exp = ref_vec(0, 5, 9, 200);
        m_ready = 1'b0;
        send_sample(1, 1);
        send_sample(200, 0); send_sample(200, 0);
        apply_reset();
        checks++; if (m_valid !== 1'b0 || err_count !== 3'd0 || s_ready !== 1'b1) begin
            failures++; $display("FAIL midreset_state: got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", m_valid, err_count, s_ready);
        end
        m_ready = 1'b1;
        send_sample(0, 0); send_sample(5, 0); send_sample(9, 0); send_sample(200, 1);
        checks++; if (m_valid !== 1'b1 || m_data !== exp) begin
            failures++; $display("FAIL midreset_clean: got v=%b d=%h want v=1 d=%h", m_valid, m_data, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_err_saturation();
        m_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 9; i++) send_sample(i, 1);
        checks++; if (err_count !== 3'd7) begin failures++; $display("FAIL sat_count: got %0d want 7", err_count); end
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL sat_pulse: got %b want 1", frame_err); end
        @(posedge clk); #1;
    endtask

    // Random frames of mixed lengths under random valid/ready, scored against a frame-level model
    task automatic test_random();
        int         sd[$];
        bit         sl[$];
        logic [7:0] exp_q[$];
        int         nerr, pos, cyc, pulses, len, r;
        int         fr[8];
        logic [7:0] e;
        m_ready = 1'b1;
        apply_reset();
        nerr = 0;
        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       len = 4;
            else if (r == 6) len = $urandom_range(1, 3);
            else             len = $urandom_range(5, 7);
            for (int k = 0; k < len; k++) begin
                fr[k] = $urandom_range(0, 255);
                sd.push_back(fr[k]);
                sl.push_back(k == len - 1);
            end
            if (len == 4) exp_q.push_back(ref_vec(fr[0], fr[1], fr[2], fr[3]));
            else          nerr++;
        end
        pos = 0; cyc = 0; pulses = 0;
        while (cyc < 4000 && (pos < sd.size() || exp_q.size() > 0)) begin
            if (frame_err) pulses++;
            s_valid = (pos < sd.size()) && ($urandom_range(0, 3) != 0);
            s_data  = (pos < sd.size()) ? sd[pos][SW-1:0] : '0;
            s_last  = s_valid && sl[pos];
            m_ready = ($urandom_range(0, 2) != 0);
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rand_extra_vector: got d=%h want no vector", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin failures++; $display("FAIL rand_vector: got %h want %h", m_data, e); end
                end
            end
            if (s_valid && s_ready) pos++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (frame_err) pulses++;
            @(posedge clk); #1;
        end
        checks++; if (pos != sd.size() || exp_q.size() != 0) begin
            failures++; $display("FAIL rand_progress: got consumed=%0d pending=%0d want consumed=%0d pending=0", pos, exp_q.size(), sd.size());
        end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rand_idle: got m_valid=%b want 0", m_valid); end
        checks++; if (pulses != nerr) begin failures++; $display("FAIL rand_err_pulses: got %0d want %0d", pulses, nerr); end
        checks++; if (int'(err_count) != ((nerr > 7) ? 7 : nerr)) begin
            failures++; $display("FAIL rand_err_count: got %0d want %0d", err_count, (nerr > 7) ? 7 : nerr);
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_short_frame();
        test_long_frame();
        test_reset_mid_frame();
        test_err_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
